// File: rtl/trace_buffer_pkg.sv
// Shared definitions for the trace recorder: FSM state codes and the
// record layout {step, insn, fetch_addr, stall, is_wb, wb_regno, wb_data}.
package trace_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } trace_state_t;

    function automatic int rec_width(input int cycle_w, input int data_w, input int regno_w);
        return cycle_w + 3 * data_w + 2 + regno_w;
    endfunction

    // Field offsets from bit 0 of a record (wb_data sits at the bottom).
    function automatic int off_wb_regno(input int data_w);
        return data_w;
    endfunction

    function automatic int off_is_wb(input int data_w, input int regno_w);
        return data_w + regno_w;
    endfunction

    function automatic int off_stall(input int data_w, input int regno_w);
        return data_w + regno_w + 1;
    endfunction

    function automatic int off_fetch(input int data_w, input int regno_w);
        return data_w + regno_w + 2;
    endfunction

    function automatic int off_insn(input int data_w, input int regno_w);
        return 2 * data_w + regno_w + 2;
    endfunction

    function automatic int off_step(input int data_w, input int regno_w);
        return 3 * data_w + regno_w + 2;
    endfunction

endpackage

// File: rtl/trace_buffer_if.sv
// Readout handshake of the trace recorder: the consumer (master) pulses
// rd_req, the recorder (slave) answers one cycle later with rd_valid/rd_data.
interface trace_buffer_if
    import trace_buffer_pkg::*;
#(
    parameter int REC_W = rec_width(32, 32, 5)
);
    logic             rd_req;
    logic             rd_valid;
    logic             rd_last;
    logic [REC_W-1:0] rd_data;

    modport master (output rd_req, input rd_valid, input rd_data, input rd_last);
    modport slave  (input rd_req, output rd_valid, output rd_data, output rd_last);
endinterface

// File: rtl/trace_buffer_ram.sv
// Simple dual-port record store: one write port, one read port with a
// registered output (data appears the cycle after re).
module trace_buffer_ram #(
    parameter int DEPTH = 16,
    parameter int REC_W = 135
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [REC_W-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [REC_W-1:0]         rdata
);
    logic [REC_W-1:0] mem [DEPTH];

    // Store one record per qualified capture cycle.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; contents are left intact so playback can repeat.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/trace_buffer.sv
// Per-cycle pipeline trace recorder: circular capture with masked
// instruction trigger and post-trigger count, then oldest-first playback.
// Optional feature macro: TRACE_STALL_FILTER_EN (drop stall-only cycles).
module trace_buffer
    import trace_buffer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REGNO_W = 5,
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        insn,
    input  logic [DATA_W-1:0]        fetch_addr,
    input  logic                     stall,
    input  logic                     is_wb,
    input  logic [REGNO_W-1:0]       wb_regno,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     arm,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        trig_insn,
    input  logic [DATA_W-1:0]        trig_mask,
    input  logic                     trig_force,
    input  logic [$clog2(DEPTH)-1:0] post_len,
    trace_buffer_if.slave            rd,
    output logic [1:0]               state_o,
    output logic                     done,
    output logic                     overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int REC_W = rec_width(CYCLE_W, DATA_W, REGNO_W);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    trace_state_t       state, state_nx;
    logic [CYCLE_W-1:0] step;
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_nx, rd_ptr, post_cnt;
    logic [PTR_W:0]     count, count_nx, remaining;
    logic               qual, trig_hit, wr_en, rd_en, arm_go, enter_done;
    logic               rd_vld_p1, rd_last_p1;
    logic [REC_W-1:0]   wr_rec, ram_q;

`ifdef TRACE_STALL_FILTER_EN
    // A fetch stall with no writeback carries no new information.
    assign qual = !(stall && !is_wb);
`else
    assign qual = 1'b1;
`endif

    assign trig_hit   = trig_force | ((insn & trig_mask) == (trig_insn & trig_mask));
    assign wr_rec     = {step, insn, fetch_addr, stall, is_wb, wb_regno, wb_data};
    assign enter_done = (state_nx == ST_DONE) && (state != ST_DONE);
    assign state_o    = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; clear overrides every other event.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (arm) state_nx = ST_PRE;
                ST_PRE:  if (qual && trig_hit) state_nx = (post_len == '0) ? ST_DONE : ST_POST;
                ST_POST: if (qual && post_cnt == PTR_W'(1)) state_nx = ST_DONE;
                ST_DONE: if (arm) state_nx = ST_PRE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Per-state strobes: record writes, arming and readout acceptance.
    always_comb begin
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        arm_go = 1'b0;
        done   = 1'b0;
        case (state)
            ST_IDLE: arm_go = arm && !clear;
            ST_PRE,
            ST_POST: wr_en = qual && !clear;
            ST_DONE: begin
                done   = 1'b1;
                arm_go = arm && !clear;
                rd_en  = rd.rd_req && !clear && (remaining != '0);
            end
            default: ;
        endcase
    end

    // Write pointer / fill count after this cycle; readout setup needs them.
    always_comb begin
        wr_ptr_nx = wr_ptr;
        count_nx  = count;
        if (arm_go) begin
            wr_ptr_nx = '0;
            count_nx  = '0;
        end else if (wr_en) begin
            wr_ptr_nx = wr_ptr + 1'b1;
            if (count != FULL) count_nx = count + 1'b1;
        end
    end

    // Free-running step stamp, untouched by arm/clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) step <= '0;
        else     step <= step + 1'b1;
    end

    // Capture and playback bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            post_cnt  <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
        end else begin
            wr_ptr <= wr_ptr_nx;
            count  <= count_nx;
            if (arm_go)                      overflow <= 1'b0;
            else if (wr_en && count == FULL) overflow <= 1'b1;
            if (wr_en) begin
                if (state == ST_PRE && trig_hit) post_cnt <= post_len;
                else if (state == ST_POST)       post_cnt <= post_cnt - 1'b1;
            end
            if (enter_done) begin
                // A wrapped buffer starts at the oldest entry, i.e. the next write slot.
                rd_ptr    <= (count_nx != FULL) ? '0 : wr_ptr_nx;
                remaining <= count_nx;
            end else if (rd_en) begin
                rd_ptr    <= rd_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    // ---- stage p1: RAM read data returns alongside its valid ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
        end else begin
            rd_vld_p1  <= rd_en;
            rd_last_p1 <= rd_en && (remaining == (PTR_W + 1)'(1));
        end
    end

    assign rd.rd_valid = rd_vld_p1;
    assign rd.rd_last  = rd_vld_p1 & rd_last_p1;
    assign rd.rd_data  = rd_vld_p1 ? ram_q : '0;

    trace_buffer_ram #(
        .DEPTH (DEPTH),
        .REC_W (REC_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_rec),
        .re    (rd_en),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );
endmodule
